// File: rtl/tinyrv1_mem_pkg.sv
// Shared types for the TinyRV1 memory arbiter: request type, transaction owner and arbiter state.
package tinyrv1_mem_pkg;

    typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} memtype_t;
    typedef enum logic {OWN_IMEM = 1'b0, OWN_DMEM = 1'b1} owner_t;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arbstate_t;

endpackage

// File: rtl/proc_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin grant on contention; otherwise loads/stores always win.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | no transaction outstanding; grant forwarded to memory port
// ARB_BUSY | one request accepted; waiting for its memory response
module proc_mem_arbiter
    import tinyrv1_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              imemreq_val,
    output logic              imemreq_rdy,
    input  logic [ADDR_W-1:0] imemreq_addr,
    output logic              imemresp_val,
    output logic [DATA_W-1:0] imemresp_data,

    input  logic              dmemreq_val,
    output logic              dmemreq_rdy,
    input  logic              dmemreq_type,
    input  logic [ADDR_W-1:0] dmemreq_addr,
    input  logic [DATA_W-1:0] dmemreq_wdata,
    output logic              dmemresp_val,
    output logic [DATA_W-1:0] dmemresp_data,

    output logic              memreq_val,
    input  logic              memreq_rdy,
    output logic              memreq_type,
    output logic [ADDR_W-1:0] memreq_addr,
    output logic [DATA_W-1:0] memreq_wdata,
    input  logic              memresp_val,
    input  logic [DATA_W-1:0] memresp_data,

    output logic              err_stray
);

    arbstate_t state, state_nxt;
    owner_t    owner;
    owner_t    grant;
    logic      grant_val;
    logic      fire;

`ifdef MEM_ARB_RR_EN
    owner_t    last_owner;
`endif

    always_comb begin
        grant_val = imemreq_val | dmemreq_val;
        grant     = OWN_IMEM;
`ifdef MEM_ARB_RR_EN
        if (imemreq_val && dmemreq_val) begin
            if (last_owner == OWN_DMEM) grant = OWN_IMEM;
            else                        grant = OWN_DMEM;
        end else if (dmemreq_val) begin
            grant = OWN_DMEM;
        end
`else
        if (dmemreq_val) grant = OWN_DMEM;
`endif
    end

    // Outputs are forced to zero for the whole time reset is held, including mid-transaction.
    always_comb begin
        state_nxt     = state;
        imemreq_rdy   = 1'b0;
        dmemreq_rdy   = 1'b0;
        imemresp_val  = 1'b0;
        imemresp_data = '0;
        dmemresp_val  = 1'b0;
        dmemresp_data = '0;
        memreq_val    = 1'b0;
        memreq_type   = MEM_READ;
        memreq_addr   = '0;
        memreq_wdata  = '0;
        if (rst) begin
            case (state)
                ARB_IDLE: begin
                    if (grant_val) begin
                        memreq_val = 1'b1;
                        if (grant == OWN_DMEM) begin
                            memreq_type  = dmemreq_type;
                            memreq_addr  = dmemreq_addr;
                            memreq_wdata = dmemreq_wdata;
                            dmemreq_rdy  = memreq_rdy;
                        end else begin
                            memreq_addr  = imemreq_addr;
                            imemreq_rdy  = memreq_rdy;
                        end
                        if (memreq_rdy) state_nxt = ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (memresp_val) begin
                        state_nxt = ARB_IDLE;
                        if (owner == OWN_DMEM) begin
                            dmemresp_val  = 1'b1;
                            dmemresp_data = memresp_data;
                        end else begin
                            imemresp_val  = 1'b1;
                            imemresp_data = memresp_data;
                        end
                    end
                end
                default: state_nxt = ARB_IDLE;
            endcase
        end
    end

    assign fire = memreq_val & memreq_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ARB_IDLE;
            owner     <= OWN_IMEM;
            err_stray <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fire) owner <= grant;
            if (state == ARB_IDLE && memresp_val) err_stray <= 1'b1;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_owner <= OWN_DMEM;
        else if (fire) last_owner <= grant;
    end
`endif

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Self-checking bench for proc_mem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference (MEM_ARB_RR_EN selects the grant rule).
module tb_proc_mem_arbiter;
    import tinyrv1_mem_pkg::*;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imemreq_val, imemreq_rdy, imemresp_val;
    logic [31:0] imemreq_addr, imemresp_data;
    logic        dmemreq_val, dmemreq_rdy, dmemreq_type, dmemresp_val;
    logic [31:0] dmemreq_addr, dmemreq_wdata, dmemresp_data;
    logic        memreq_val, memreq_rdy, memreq_type, memresp_val;
    logic [31:0] memreq_addr, memreq_wdata, memresp_data;
    logic        err_stray;

    always #5 clk = ~clk;

    proc_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
        .imemresp_val(imemresp_val), .imemresp_data(imemresp_data),
        .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
        .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
        .dmemresp_val(dmemresp_val), .dmemresp_data(dmemresp_data),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
        .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
        .memresp_val(memresp_val), .memresp_data(memresp_data),
        .err_stray(err_stray)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imemreq_val = 1'b0; imemreq_addr = '0;
        dmemreq_val = 1'b0; dmemreq_type = 1'b0; dmemreq_addr = '0; dmemreq_wdata = '0;
        memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    typedef struct {
        logic        i_val;
        logic [31:0] i_addr;
        logic        d_val;
        logic        d_type;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        m_rdy;
        logic [31:0] r_data;
        logic        e_mval;
        logic        e_type;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_irdy;
        logic        e_drdy;
    } vec_t;

    vec_t vecs[7];

    // reference model state for the random run
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];
    bit          m_busy;
    owner_t      m_own, m_last;
    logic [31:0] m_exp;
    bit          mem_pend;
    int          mem_wait;
    logic [31:0] mem_data;
    bit          i_done, d_done;

    initial begin
        bit first_i;
        bit exp_mval, exp_irdy, exp_drdy, pick_d, exp_iresp, exp_dresp;

        vecs[0] = '{1'b0, 32'h0,     1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0,
                    1'b0, 1'b0, 32'h0,     32'h0,        1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h300,   1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0,
                    1'b1, 1'b0, 32'h300,   32'h0,        1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h304,   1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0000_0093,
                    1'b1, 1'b0, 32'h304,   32'h0,        1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h2000, 32'h0,        1'b1, 32'hAAAA_5555,
                    1'b1, 1'b0, 32'h2000,  32'h0,        1'b0, 1'b1};
        vecs[4] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 1'b0, 32'h0,
                    1'b1, 1'b1, 32'h2004,  32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h2008, 32'h0BAD_F00D, 1'b1, 32'h0,
                    1'b1, 1'b1, 32'h2008,  32'h0BAD_F00D, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 32'h308,   1'b0, 1'b1, 32'h9999, 32'h1234,     1'b1, 32'h1234_5678,
                    1'b1, 1'b0, 32'h308,   32'h0,        1'b1, 1'b0};

        // reset with every input asserted: outputs must all be zero
        clear_inputs();
        rst = 1'b0;
        #2;
        imemreq_val = 1'b1; imemreq_addr = 32'h100;
        dmemreq_val = 1'b1; dmemreq_addr = 32'h200; dmemreq_wdata = 32'hFFFF;
        memreq_rdy = 1'b1; memresp_val = 1'b1; memresp_data = 32'hABCD;
        #1;
        chk1("rst memreq_val", memreq_val, 1'b0);
        chk1("rst imemreq_rdy", imemreq_rdy, 1'b0);
        chk1("rst dmemreq_rdy", dmemreq_rdy, 1'b0);
        chk1("rst imemresp_val", imemresp_val, 1'b0);
        chk1("rst dmemresp_val", dmemresp_val, 1'b0);
        chk32("rst memreq_addr", memreq_addr, 32'h0);
        chk32("rst memreq_wdata", memreq_wdata, 32'h0);
        chk1("rst err_stray", err_stray, 1'b0);
        do_reset();

        // vector table, single requester patterns from IDLE
        for (int k = 0; k < 7; k++) begin
            imemreq_val = vecs[k].i_val; imemreq_addr = vecs[k].i_addr;
            dmemreq_val = vecs[k].d_val; dmemreq_type = vecs[k].d_type;
            dmemreq_addr = vecs[k].d_addr; dmemreq_wdata = vecs[k].d_wdata;
            memreq_rdy = vecs[k].m_rdy;
            #1;
            chk1($sformatf("vec%0d memreq_val", k), memreq_val, vecs[k].e_mval);
            chk1($sformatf("vec%0d imemreq_rdy", k), imemreq_rdy, vecs[k].e_irdy);
            chk1($sformatf("vec%0d dmemreq_rdy", k), dmemreq_rdy, vecs[k].e_drdy);
            if (vecs[k].e_mval) begin
                chk1($sformatf("vec%0d memreq_type", k), memreq_type, vecs[k].e_type);
                chk32($sformatf("vec%0d memreq_addr", k), memreq_addr, vecs[k].e_addr);
                chk32($sformatf("vec%0d memreq_wdata", k), memreq_wdata, vecs[k].e_wdata);
            end
            tick();
            clear_inputs();
            if (vecs[k].e_irdy || vecs[k].e_drdy) begin
                memresp_val = 1'b1; memresp_data = vecs[k].r_data;
                #1;
                chk1($sformatf("vec%0d imemresp_val", k), imemresp_val, vecs[k].e_irdy);
                chk1($sformatf("vec%0d dmemresp_val", k), dmemresp_val, vecs[k].e_drdy);
                chk32($sformatf("vec%0d resp_data", k),
                      vecs[k].e_irdy ? imemresp_data : dmemresp_data, vecs[k].r_data);
                tick();
                memresp_val = 1'b0;
            end
        end

        // fetch: 0x200 granted, BUSY blocks, response routed to imem
        do_reset();
        imemreq_val = 1'b1; imemreq_addr = 32'h200; memreq_rdy = 1'b1;
        #1;
        chk32("t1 memreq_addr", memreq_addr, 32'h200);
        chk1("t1 imemreq_rdy", imemreq_rdy, 1'b1);
        tick();
        #1;
        chk1("t1 busy memreq_val", memreq_val, 1'b0);
        chk1("t1 busy imemreq_rdy", imemreq_rdy, 1'b0);
        chk1("t1 busy no resp", imemresp_val, 1'b0);
        imemreq_val = 1'b0;
        memresp_val = 1'b1; memresp_data = 32'h0000_0013;
        #1;
        chk1("t1 imemresp_val", imemresp_val, 1'b1);
        chk32("t1 imemresp_data", imemresp_data, 32'h0000_0013);
        chk1("t1 dmemresp_val", dmemresp_val, 1'b0);
        tick();
        memresp_val = 1'b0;
        #1;
        chk1("t1 idle imemresp_val", imemresp_val, 1'b0);

        // contention: fixed priority picks dmem, round-robin from reset picks imem
        do_reset();
        first_i = RR;
        imemreq_val = 1'b1; imemreq_addr = 32'h204;
        dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h1000;
        memreq_rdy = 1'b1;
        #1;
        chk32("t2 first addr", memreq_addr, first_i ? 32'h204 : 32'h1000);
        chk1("t2 first imemreq_rdy", imemreq_rdy, first_i);
        chk1("t2 first dmemreq_rdy", dmemreq_rdy, !first_i);
        tick();
        if (first_i) imemreq_val = 1'b0;
        else         dmemreq_val = 1'b0;
        #1;
        chk1("t2 busy memreq_val", memreq_val, 1'b0);
        chk1("t2 busy loser rdy", first_i ? dmemreq_rdy : imemreq_rdy, 1'b0);
        memresp_val = 1'b1; memresp_data = 32'h55;
        #1;
        chk1("t2 first imemresp_val", imemresp_val, first_i);
        chk1("t2 first dmemresp_val", dmemresp_val, !first_i);
        chk32("t2 first resp_data", first_i ? imemresp_data : dmemresp_data, 32'h55);
        tick();
        memresp_val = 1'b0;
        #1;
        chk1("t2 second memreq_val", memreq_val, 1'b1);
        chk32("t2 second addr", memreq_addr, first_i ? 32'h1000 : 32'h204);
        chk1("t2 second imemreq_rdy", imemreq_rdy, !first_i);
        chk1("t2 second dmemreq_rdy", dmemreq_rdy, first_i);
        tick();
        imemreq_val = 1'b0; dmemreq_val = 1'b0;
        memresp_val = 1'b1; memresp_data = 32'h66;
        #1;
        chk1("t2 second imemresp_val", imemresp_val, !first_i);
        chk1("t2 second dmemresp_val", dmemresp_val, first_i);
        chk32("t2 second resp_data", first_i ? dmemresp_data : imemresp_data, 32'h66);
        tick();
        memresp_val = 1'b0;

        // store stalled by memory for three cycles, fields stable throughout
        dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h1004; dmemreq_wdata = 32'hCAFE;
        memreq_rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk1($sformatf("t4 stall%0d dmemreq_rdy", s), dmemreq_rdy, 1'b0);
            chk1($sformatf("t4 stall%0d memreq_val", s), memreq_val, 1'b1);
            chk1($sformatf("t4 stall%0d memreq_type", s), memreq_type, 1'b1);
            chk32($sformatf("t4 stall%0d memreq_addr", s), memreq_addr, 32'h1004);
            chk32($sformatf("t4 stall%0d memreq_wdata", s), memreq_wdata, 32'hCAFE);
            tick();
        end
        memreq_rdy = 1'b1;
        #1;
        chk1("t4 fire dmemreq_rdy", dmemreq_rdy, 1'b1);
        tick();
        dmemreq_val = 1'b0; memreq_rdy = 1'b0;
        memresp_val = 1'b1; memresp_data = 32'h0;
        #1;
        chk1("t4 dmemresp_val", dmemresp_val, 1'b1);
        chk32("t4 dmemresp_data", dmemresp_data, 32'h0);
        chk1("t4 imemresp_val", imemresp_val, 1'b0);
        tick();
        memresp_val = 1'b0;

        // randomized traffic against the transaction-level model
        do_reset();
        m_busy = 1'b0; m_own = OWN_IMEM; m_last = OWN_DMEM; m_exp = '0;
        mem_pend = 1'b0; mem_wait = 0; mem_data = '0;
        i_done = 1'b0; d_done = 1'b0;
        for (int c = 0; c < 3010; c++) begin
            if (i_done) begin imemreq_val = 1'b0; i_done = 1'b0; end
            if (d_done) begin dmemreq_val = 1'b0; d_done = 1'b0; end
            if (c >= 3000) begin
                imemreq_val = 1'b0; dmemreq_val = 1'b0;
            end else begin
                if (!imemreq_val) begin
                    if ($urandom_range(2) == 0) begin
                        imemreq_val = 1'b1;
                        imemreq_addr = 32'($urandom_range(15)) << 2;
                    end
                end else if ($urandom_range(15) == 0) begin
                    imemreq_val = 1'b0;
                end
                if (!dmemreq_val) begin
                    if ($urandom_range(2) == 0) begin
                        dmemreq_val = 1'b1;
                        dmemreq_type = 1'($urandom_range(1));
                        dmemreq_addr = 32'($urandom_range(15)) << 2;
                        dmemreq_wdata = $urandom;
                    end
                end else if ($urandom_range(15) == 0) begin
                    dmemreq_val = 1'b0;
                end
            end
            memreq_rdy = ($urandom_range(3) != 0);
            memresp_val = 1'b0;
            memresp_data = $urandom;
            if (mem_pend) begin
                if (mem_wait == 0) begin
                    memresp_val = 1'b1; memresp_data = mem_data; mem_pend = 1'b0;
                end else begin
                    mem_wait--;
                end
            end
            #3;
            exp_mval = 1'b0; exp_irdy = 1'b0; exp_drdy = 1'b0; pick_d = 1'b0;
            if (!m_busy && (imemreq_val || dmemreq_val)) begin
                exp_mval = 1'b1;
                if (imemreq_val && dmemreq_val) pick_d = RR ? (m_last == OWN_IMEM) : 1'b1;
                else                            pick_d = dmemreq_val;
                exp_irdy = !pick_d && memreq_rdy;
                exp_drdy = pick_d && memreq_rdy;
            end
            chk1("rnd memreq_val", memreq_val, exp_mval);
            chk1("rnd imemreq_rdy", imemreq_rdy, exp_irdy);
            chk1("rnd dmemreq_rdy", dmemreq_rdy, exp_drdy);
            if (exp_mval) begin
                chk1("rnd memreq_type", memreq_type, pick_d ? dmemreq_type : 1'b0);
                chk32("rnd memreq_addr", memreq_addr, pick_d ? dmemreq_addr : imemreq_addr);
                chk32("rnd memreq_wdata", memreq_wdata, pick_d ? dmemreq_wdata : 32'h0);
            end
            exp_iresp = m_busy && memresp_val && (m_own == OWN_IMEM);
            exp_dresp = m_busy && memresp_val && (m_own == OWN_DMEM);
            chk1("rnd imemresp_val", imemresp_val, exp_iresp);
            chk1("rnd dmemresp_val", dmemresp_val, exp_dresp);
            if (exp_iresp) chk32("rnd imemresp_data", imemresp_data, m_exp);
            if (exp_dresp) chk32("rnd dmemresp_data", dmemresp_data, m_exp);

            if (memreq_val && memreq_rdy) begin
                mem_pend = 1'b1;
                mem_wait = int'($urandom_range(2));
                if (memreq_type) begin
                    phys_mem[memreq_addr] = memreq_wdata;
                    mem_data = 32'h0;
                end else begin
                    mem_data = phys_mem.exists(memreq_addr) ? phys_mem[memreq_addr]
                                                            : init_word(memreq_addr);
                end
            end

            if (m_busy && memresp_val) begin
                m_busy = 1'b0;
            end else if (exp_drdy) begin
                m_busy = 1'b1; m_own = OWN_DMEM; m_last = OWN_DMEM; d_done = 1'b1;
                if (dmemreq_type) begin
                    ref_mem[dmemreq_addr] = dmemreq_wdata;
                    m_exp = 32'h0;
                end else begin
                    m_exp = ref_mem.exists(dmemreq_addr) ? ref_mem[dmemreq_addr]
                                                         : init_word(dmemreq_addr);
                end
            end else if (exp_irdy) begin
                m_busy = 1'b1; m_own = OWN_IMEM; m_last = OWN_IMEM; i_done = 1'b1;
                m_exp = ref_mem.exists(imemreq_addr) ? ref_mem[imemreq_addr]
                                                     : init_word(imemreq_addr);
            end
            tick();
        end
        chk1("rnd err_stray clear", err_stray, 1'b0);

        // stray response while idle is dropped and latched
        clear_inputs();
        tick();
        memresp_val = 1'b1; memresp_data = 32'h77;
        #1;
        chk1("t5 imemresp_val", imemresp_val, 1'b0);
        chk1("t5 dmemresp_val", dmemresp_val, 1'b0);
        tick();
        memresp_val = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk1($sformatf("t5 err_stray hold%0d", s), err_stray, 1'b1);
            tick();
        end

        // reset mid-transaction, late response, then a clean grant
        imemreq_val = 1'b1; imemreq_addr = 32'h400; memreq_rdy = 1'b1;
        tick();
        #2;
        rst = 1'b0;
        dmemreq_val = 1'b1; dmemreq_addr = 32'h500;
        memresp_val = 1'b1; memresp_data = 32'hFFFF;
        #1;
        chk1("t6 rst memreq_val", memreq_val, 1'b0);
        chk1("t6 rst imemreq_rdy", imemreq_rdy, 1'b0);
        chk1("t6 rst dmemreq_rdy", dmemreq_rdy, 1'b0);
        chk1("t6 rst imemresp_val", imemresp_val, 1'b0);
        chk32("t6 rst imemresp_data", imemresp_data, 32'h0);
        chk1("t6 rst dmemresp_val", dmemresp_val, 1'b0);
        chk32("t6 rst memreq_addr", memreq_addr, 32'h0);
        chk1("t6 rst err_stray", err_stray, 1'b0);
        clear_inputs();
        tick();
        rst = 1'b1;
        memresp_val = 1'b1; memresp_data = 32'h88;
        #1;
        chk1("t6 late imemresp_val", imemresp_val, 1'b0);
        tick();
        memresp_val = 1'b0;
        #1;
        chk1("t6 late err_stray", err_stray, 1'b1);
        imemreq_val = 1'b1; imemreq_addr = 32'h404; memreq_rdy = 1'b1;
        #1;
        chk1("t6 regrant imemreq_rdy", imemreq_rdy, 1'b1);
        chk32("t6 regrant addr", memreq_addr, 32'h404);
        tick();
        clear_inputs();
        memresp_val = 1'b1; memresp_data = 32'h0000_0033;
        #1;
        chk1("t6 resp imemresp_val", imemresp_val, 1'b1);
        chk32("t6 resp imemresp_data", imemresp_data, 32'h0000_0033);
        tick();
        memresp_val = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
